clk_div_prog: RTL and testbench

- Runtime-programmable clock divider; parametrised successor of the fixed clk_div.
- Produces a registered, glitch-free divided clock clk_out and a one-cycle tick strobe at each clk_out rising edge, with an enable input.
- The divisor is loaded at runtime through a load/ack handshake and takes effect only at a period boundary.
- Sits between the system clock and slow downstream logic (blinkers, display scan, timers).

---
 rtl/clk_div_pkg.sv | 24 ++
 rtl/clk_div_cfg.sv | 58 +++++
 rtl/clk_div_prog.sv | 84 ++++++++
 tb/tb_clk_div_prog.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Pure combinational helpers, no latency.
// No flow control; used by clk_div_cfg and clk_div_prog.
package clk_div_pkg;

    // Smallest divisor that still gives a real high and low phase.
    localparam int MIN_DIV       = 2;
    localparam int CNT_W_DEFAULT = 24;

    // Helpers work at a fixed 32-bit width; callers size-cast in and out,
    // which limits CNT_W to 32 bits.
    localparam int DIV_W = 32;

    // ceil(d/2) without needing an extra bit: (d>>1) + d[0].
    function automatic logic [DIV_W-1:0] half_up(input logic [DIV_W-1:0] d);
        return (d >> 1) + {{(DIV_W-1){1'b0}}, d[0]};
    endfunction

    // max(d, MIN_DIV): divisors 0 and 1 are not meaningful.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : d;
    endfunction

endpackage

// File: rtl/clk_div_cfg.sv
// Divisor staging: shadow register, pending flag and one-cycle apply ack.
// Load is captured on the edge it is seen; apply happens at a period boundary.
// No backpressure: later loads overwrite the shadow, one ack per apply.
module clk_div_cfg
    import clk_div_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEFAULT,
    parameter int DIV_RESET = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             div_load_i,
    input  logic [CNT_W-1:0] div_in_i,
    input  logic             boundary_i,
    output logic             apply_o,
    output logic [CNT_W-1:0] shadow_o,
    output logic             div_ack_o
);

    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             ack_q;
    logic             apply;

    // The counter uses the shadow as it is before this edge, so a load
    // arriving on the apply edge stays pending for the next boundary.
    assign apply = pending_q && boundary_i;

    // Next-state: a fresh load always wins the pending flag.
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (div_load_i) begin
            shadow_d  = CNT_W'(clamp_div(32'(div_in_i)));
            pending_d = 1'b1;
        end else if (apply) begin
            pending_d = 1'b0;
        end
    end

    // Staging registers and the ack pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q  <= CNT_W'(DIV_RESET);
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ack_q     <= apply;
        end
    end

    assign apply_o   = apply;
    assign shadow_o  = shadow_q;
    assign div_ack_o = ack_q;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider with registered clk_out and tick strobe.
// Outputs registered from next counter value; tick on the first enabled edge.
// New divisor waits for the end of the current period (immediate when idle).
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEFAULT,
    parameter int DIV_RESET = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] d_act_q, d_act_d;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] shadow;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             wrap;
    logic             boundary;
    logic             apply;

    // Last cycle of the current period.
    assign wrap     = (cnt_q == d_act_q - CNT_W'(1));
    // While stopped there is no period in flight, so any edge is a boundary.
    assign boundary = en ? wrap : 1'b1;

    clk_div_cfg #(
        .CNT_W     (CNT_W),
        .DIV_RESET (DIV_RESET)
    ) u_cfg (
        .clk_i      (clk),
        .rst_i      (rst),
        .div_load_i (div_load),
        .div_in_i   (div_in),
        .boundary_i (boundary),
        .apply_o    (apply),
        .shadow_o   (shadow),
        .div_ack_o  (div_ack)
    );

    // High-phase length comes from the divisor governing the next period.
    assign half = CNT_W'(half_up(32'(d_act_d)));

    // Next counter and output values; stopping parks cnt at D-1 so the
    // first enabled edge wraps to 0 and starts a full period.
    always_comb begin
        d_act_d   = apply ? shadow : d_act_q;
        cnt_d     = d_act_d - CNT_W'(1);
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        if (en) begin
            cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
            clk_out_d = (cnt_d < half);
            tick_d    = (cnt_d == '0);
        end
    end

    // Counter, active divisor and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= CNT_W'(DIV_RESET - 1);
            d_act_q   <= CNT_W'(DIV_RESET);
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            d_act_q   <= d_act_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with hand-computed waveforms.
// Inputs change 1ns after a rising edge; outputs sampled at the same point.
// No flow control involved; every check goes through one task.
module tb_clk_div_prog;

    localparam int CNT_W = 24;

    logic             clk;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] div_in;
    logic             div_load;
    logic             div_ack;
    logic             clk_out;
    logic             tick;

    int n_chk  = 0;
    int n_pass = 0;

    clk_div_prog #(
        .CNT_W     (CNT_W),
        .DIV_RESET (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .div_ack  (div_ack),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run edges for phase positions k_from..k_to of a period of length d.
    // Expected: high for the first ceil(d/2) positions, tick at position 0,
    // ack only at position ack_k (-1 for none).
    task automatic run_span(input int d, input int k_from, input int k_to, input int ack_k);
        for (int k = k_from; k <= k_to; k++) begin
            step();
            check($sformatf("clk_out d%0d k%0d", d, k), 32'(clk_out), 32'(k < (d + 1) / 2));
            check($sformatf("tick d%0d k%0d", d, k), 32'(tick), 32'(k == 0));
            check($sformatf("ack d%0d k%0d", d, k), 32'(div_ack), 32'(k == ack_k));
        end
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        div_in   = '0;
        div_load = 1'b0;

        // Reset state
        step();
        step();
        check("rst clk_out", 32'(clk_out), 32'd0);
        check("rst tick", 32'(tick), 32'd0);
        check("rst ack", 32'(div_ack), 32'd0);

        // Default divisor 10: 5 high / 5 low, immediate rise on enable
        rst = 1'b0;
        en  = 1'b1;
        run_span(10, 0, 9, -1);
        run_span(10, 0, 9, -1);

        // Load 5 mid-high-phase: period of 10 completes, then 3/2
        run_span(10, 0, 1, -1);
        div_in   = 24'd5;
        div_load = 1'b1;
        run_span(10, 2, 2, -1);
        div_load = 1'b0;
        run_span(10, 3, 9, -1);
        run_span(5, 0, 4, 0);
        run_span(5, 0, 4, -1);

        // Load 0 then 1: both clamp to 2
        div_in   = 24'd0;
        div_load = 1'b1;
        run_span(5, 0, 0, -1);
        div_load = 1'b0;
        run_span(5, 1, 4, -1);
        run_span(2, 0, 1, 0);
        run_span(2, 0, 1, -1);
        div_in   = 24'd1;
        div_load = 1'b1;
        run_span(2, 0, 0, -1);
        div_load = 1'b0;
        run_span(2, 1, 1, -1);
        run_span(2, 0, 1, 0);
        run_span(2, 0, 1, -1);

        // Two loads (7 then 4) before the boundary: last wins, one ack
        div_in   = 24'd7;
        div_load = 1'b1;
        run_span(2, 0, 0, -1);
        div_in   = 24'd4;
        run_span(2, 1, 1, -1);
        div_load = 1'b0;
        run_span(4, 0, 3, 0);
        run_span(4, 0, 3, -1);

        // Load on the apply edge: 3 applies now, 8 pends with its own ack
        div_in   = 24'd3;
        div_load = 1'b1;
        run_span(4, 0, 0, -1);
        div_load = 1'b0;
        run_span(4, 1, 3, -1);
        div_in   = 24'd8;
        div_load = 1'b1;
        run_span(3, 0, 0, 0);
        div_load = 1'b0;
        run_span(3, 1, 2, -1);
        run_span(8, 0, 7, 0);

        // Drop en in the high phase with 6 pending
        run_span(8, 0, 1, -1);
        div_in   = 24'd6;
        div_load = 1'b1;
        run_span(8, 2, 2, -1);
        div_load = 1'b0;
        en       = 1'b0;
        step();
        check("en0 clk_out", 32'(clk_out), 32'd0);
        check("en0 tick", 32'(tick), 32'd0);
        check("en0 ack", 32'(div_ack), 32'd1);
        step();
        check("en0b clk_out", 32'(clk_out), 32'd0);
        check("en0b ack", 32'(div_ack), 32'd0);
        en = 1'b1;
        run_span(6, 0, 5, -1);
        run_span(6, 0, 5, -1);

        // Reset with a load pending: back to 10, no stale ack
        run_span(6, 0, 1, -1);
        div_in   = 24'd3;
        div_load = 1'b1;
        run_span(6, 2, 2, -1);
        div_load = 1'b0;
        rst      = 1'b1;
        step();
        check("midrst clk_out", 32'(clk_out), 32'd0);
        check("midrst tick", 32'(tick), 32'd0);
        check("midrst ack", 32'(div_ack), 32'd0);
        step();
        check("midrst2 clk_out", 32'(clk_out), 32'd0);
        rst = 1'b0;
        run_span(10, 0, 9, -1);
        run_span(10, 0, 9, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
